quiz_round_sequencer: RTL and testbench
=======================================

# quiz_round_sequencer

Round controller for the hex quiz game. Requests each question target, starts the external countdown timer, and captures the player's switch answer on a debounced-edge press of the choose key. Judges each answer against the target, keeps the score and round count, and paces the rounds. It sits between the SoC (question source, score readout) and the countdown timer. Its state code drives the HEX4 digit.

## Interface
- ROUNDS, 10, number of questions per game (1..255)
- ANS_W, 9, answer/target width (SW[8:0])
- SHOW_CYCLES, 50_000_000, cycles the verdict is held before the next round (1 s at 50 MHz); must be at least 1
- clk  in  1  system clock (MAX10_CLK1_50)
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a new game from IDLE or DONE
- choose_n  in  1  raw active-low choose button (KEY[1]), asynchronous to clk
- answer  in  ANS_W  player answer (switches), sampled at the press
- target  in  ANS_W  question answer from the SoC; valid when target_valid=1
- target_valid  in  1  target handshake valid
- q_req  out  1  question request; target handshake ready
- timer_reload  out  1  one-cycle pulse that restarts the countdown (drives countdown reset)
- timer_expired  in  1  countdown-remaining-zero flag (rem)
- state  out  3  FSM code: IDLE=0, REQ=1, ASK=2, JUDGE=3, SHOW=4, DONE=5
- score  out  8  points, saturating at 255
- round  out  8  rounds judged this game
- verdict  out  2  {valid, correct}; held from JUDGE through SHOW
- busy  out  1  high in every state except IDLE and DONE

## Operation
- choose_n goes through a 2-flop synchroniser followed by a history flop. A press event is synced-low combined with history-high (falling edge).
- IDLE: all counters are idle. On start: score=0, round=0, streak=0, next state REQ.
- REQ: q_req=1. The transfer happens in the cycle where q_req and target_valid are both high. On transfer: latch target, pulse timer_reload for 1 cycle, next state ASK.
- ASK: on a press event, latch answer and go to JUDGE with timeout=0. On timer_expired, go to JUDGE with timeout=1. If both occur in the same cycle, the press wins (timeout=0).
- JUDGE (1 cycle): correct = !timeout && answer==target.
  - On correct: score += 1 (saturating), streak++.
  - Otherwise: streak=0.
  - Always: round += 1, verdict={1,correct}. Next state SHOW with the hold counter loaded to SHOW_CYCLES-1.
- SHOW: hold counter decrements each cycle. At 0: if round==ROUNDS go to DONE, else go to REQ and set verdict=0.
- DONE: outputs hold, including the final verdict. start behaves as in IDLE (clears, then REQ).
- Events that are ignored:
  - Press events outside ASK; they are not queued.
  - timer_expired outside ASK.
  - target_valid outside REQ.
  - start while busy.
- No arithmetic wraps: score saturates at 255; round never exceeds ROUNDS.

## Timing
- All outputs reset asynchronously: state=IDLE(0), q_req=0, timer_reload=0, score=0, round=0, verdict=0, busy=0. Internal streak, hold counter and latches reset to 0. Synchroniser flops reset to 1 (button released).
- choose_n falls before edge 0 → state=JUDGE after edge 2 → score, round and verdict updated and state=SHOW after edge 3.
- Target handshake at edge t: state=ASK and timer_reload=1 during cycle t..t+1 only.
- SHOW lasts exactly SHOW_CYCLES cycles.
- Reset mid-game: immediate return to IDLE; q_req and timer_reload drop asynchronously.
- target and answer must be stable in the cycle of the transfer or press event; they are sampled only then.

## Configuration
- QUIZ_STREAK_BONUS_EN defined:
  - When a correct answer brings streak to 3, that answer adds 3 points instead of 1, and streak is reset to 0.
  - Saturation at 255 still applies.
- QUIZ_STREAK_BONUS_EN undefined:
  - Every correct answer adds 1 point.
  - The streak register is not built.

## Test plan
- Reset then idle: after reset_n deasserts, state=0, score=0, q_req=0. start pulse → state=1, q_req=1 next cycle.
- Correct answer: target=0x1A5 handshake, answer=0x1A5, press choose_n → JUDGE 2 cycles after the press, then score=1, round=1, verdict=2'b11. With SHOW_CYCLES=4, state=REQ 4 cycles after entering SHOW.
- Timeout, plus press colliding with expiry:
  - timer_expired in ASK with no press → verdict=2'b10, score unchanged.
  - Press and expiry in the same cycle with answer==target → verdict=2'b11.
- Full game, ROUNDS=3, all correct:
  - Without the macro: state=DONE with score=3, round=3.
  - With QUIZ_STREAK_BONUS_EN: score=5.
  - A start pulse in DONE clears score and round to 0.
- Robustness:
  - Press in REQ → no JUDGE.
  - start during ASK → no effect.
  - Assert reset_n low during SHOW → state=0 and score=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/quiz_round_sequencer.sv
// Round controller for the hex quiz game: question handshake, countdown restart,
// debounced answer capture, judging, scoring and round pacing. Optional: QUIZ_STREAK_BONUS_EN.
module quiz_round_sequencer #(
    parameter int ROUNDS      = 10,
    parameter int ANS_W       = 9,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             choose_n,
    input  logic [ANS_W-1:0] answer,
    input  logic [ANS_W-1:0] target,
    input  logic             target_valid,
    output logic             q_req,
    output logic             timer_reload,
    input  logic             timer_expired,
    output logic [2:0]       state,
    output logic [7:0]       score,
    output logic [7:0]       round,
    output logic [1:0]       verdict,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ASK   = 3'd2,
        S_JUDGE = 3'd3,
        S_SHOW  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int HW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(SHOW_CYCLES - 1);
    localparam logic [7:0]    LAST_ROUND = 8'(ROUNDS);

    state_t           r_state, w_next;
    logic             r_sync1, r_sync2, r_hist;
    logic             r_reload, r_timeout;
    logic [ANS_W-1:0] r_answer, r_target;
    logic [HW-1:0]    r_hold;
    logic [7:0]       r_score, r_round;
    logic [1:0]       r_verdict;
    logic             w_press, w_correct, w_last;
    logic [7:0]       w_inc;
    logic [8:0]       w_sum;

    // Falling edge of the synchronised button: synced low while history still high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= choose_n;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end
    assign w_press   = !r_sync2 && r_hist;
    assign w_correct = !r_timeout && (r_answer == r_target);
    assign w_last    = (r_round == LAST_ROUND);

`ifdef QUIZ_STREAK_BONUS_EN
    logic [1:0] r_streak;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_streak <= 2'd0;
        else if ((r_state == S_IDLE || r_state == S_DONE) && start)
            r_streak <= 2'd0;
        else if (r_state == S_JUDGE)
            r_streak <= (w_correct && r_streak != 2'd2) ? r_streak + 2'd1 : 2'd0;
    end
    // Third correct answer in a row is worth three points and restarts the streak.
    assign w_inc = (r_streak == 2'd2) ? 8'd3 : 8'd1;
`else
    assign w_inc = 8'd1;
`endif

    assign w_sum = {1'b0, r_score} + {1'b0, w_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_REQ;
            S_REQ:          if (target_valid) w_next = S_ASK;
            S_ASK:          if (w_press || timer_expired) w_next = S_JUDGE;
            S_JUDGE:        w_next = S_SHOW;
            S_SHOW:         if (r_hold == '0) w_next = w_last ? S_DONE : S_REQ;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload  <= 1'b0;
            r_timeout <= 1'b0;
            r_answer  <= '0;
            r_target  <= '0;
            r_hold    <= '0;
            r_score   <= 8'd0;
            r_round   <= 8'd0;
            r_verdict <= 2'b00;
        end else begin
            r_reload <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_score   <= 8'd0;
                    r_round   <= 8'd0;
                    r_verdict <= 2'b00;
                end
                S_REQ: if (target_valid) begin
                    r_target <= target;
                    r_reload <= 1'b1;
                end
                S_ASK: if (w_press) begin
                    r_answer  <= answer;
                    r_timeout <= 1'b0;
                end else if (timer_expired) begin
                    r_timeout <= 1'b1;
                end
                S_JUDGE: begin
                    r_verdict <= {1'b1, w_correct};
                    if (!w_last) r_round <= r_round + 8'd1;
                    if (w_correct) r_score <= w_sum[8] ? 8'hFF : w_sum[7:0];
                    r_hold <= HOLD_LOAD;
                end
                S_SHOW: begin
                    if (r_hold != '0) r_hold <= r_hold - 1'b1;
                    else if (!w_last) r_verdict <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign state        = r_state;
    assign q_req        = (r_state == S_REQ);
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign timer_reload = r_reload;
    assign score        = r_score;
    assign round        = r_round;
    assign verdict      = r_verdict;

endmodule

// File: tb/tb_quiz_round_sequencer.sv
// Bench for quiz_round_sequencer (ROUNDS=3, SHOW_CYCLES=4): directed scenarios plus
// randomized games scored by a round-level reference model.
module tb_quiz_round_sequencer;
    localparam int ROUNDS = 3;
    localparam int SHOW   = 4;
`ifdef QUIZ_STREAK_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, choose_n = 1'b1;
    logic       target_valid = 1'b0, timer_expired = 1'b0;
    logic [8:0] answer = '0, target = '0;
    logic       q_req, timer_reload, busy;
    logic [2:0] state;
    logic [7:0] score, round;
    logic [1:0] verdict;

    int n_checks = 0, n_fail = 0;
    int m_score = 0, m_round = 0, m_streak = 0;

    quiz_round_sequencer #(.ROUNDS(ROUNDS), .ANS_W(9), .SHOW_CYCLES(SHOW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .choose_n(choose_n),
        .answer(answer), .target(target), .target_valid(target_valid),
        .q_req(q_req), .timer_reload(timer_reload), .timer_expired(timer_expired),
        .state(state), .score(score), .round(round), .verdict(verdict), .busy(busy));

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_new_game();
        m_score = 0; m_round = 0; m_streak = 0;
    endtask

    task automatic model_judge(input bit correct);
        if (correct) begin
            m_streak++;
            if (BONUS && m_streak == 3) begin m_score += 3; m_streak = 0; end
            else m_score += 1;
            if (m_score > 255) m_score = 255;
        end else m_streak = 0;
        if (m_round < ROUNDS) m_round++;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic handshake(input logic [8:0] t);
        target = t; target_valid = 1'b1; step();
        target_valid = 1'b0; target = 9'($urandom);
    endtask

    task automatic press(input logic [8:0] a);
        answer = a; choose_n = 1'b0;
        step(); step(); step();
        choose_n = 1'b1; answer = 9'($urandom);
    endtask

    task automatic expire();
        timer_expired = 1'b1; step(); timer_expired = 1'b0;
    endtask

    task automatic collide(input logic [8:0] a);
        answer = a; choose_n = 1'b0;
        step(); step();
        timer_expired = 1'b1; step();
        timer_expired = 1'b0; choose_n = 1'b1;
    endtask

    task automatic leave_show(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < SHOW + 3; i++) begin
            if (state !== 3'd4) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; step(); step(); reset_n = 1'b1; step();
        n_checks++; if (state !== 3'd0 || score !== 8'd0 || round !== 8'd0 || q_req !== 1'b0 ||
                        busy !== 1'b0 || verdict !== 2'b00 || timer_reload !== 1'b0) begin
            n_fail++; $display("FAIL reset: state=%0d score=%0d round=%0d q_req=%b busy=%b verdict=%b reload=%b, want all 0",
                               state, score, round, q_req, busy, verdict, timer_reload); end
        pulse_start();
        n_checks++; if (state !== 3'd1 || q_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL start: state=%0d q_req=%b busy=%b, want 1 1 1", state, q_req, busy); end
        model_new_game();
    endtask

    task automatic test_correct();
        handshake(9'h1A5);
        n_checks++; if (state !== 3'd2 || timer_reload !== 1'b1 || q_req !== 1'b0) begin
            n_fail++; $display("FAIL handshake: state=%0d reload=%b q_req=%b, want 2 1 0", state, timer_reload, q_req); end
        step();
        n_checks++; if (timer_reload !== 1'b0) begin
            n_fail++; $display("FAIL reload_pulse: reload=%b, want 0", timer_reload); end
        press(9'h1A5);
        n_checks++; if (state !== 3'd3) begin
            n_fail++; $display("FAIL press_latency: state=%0d, want 3", state); end
        step(); model_judge(1'b1);
        n_checks++; if (state !== 3'd4 || score !== 8'(m_score) || round !== 8'(m_round) || verdict !== 2'b11) begin
            n_fail++; $display("FAIL correct_judge: state=%0d score=%0d round=%0d verdict=%b, want 4 %0d %0d 11",
                               state, score, round, verdict, m_score, m_round); end
        for (int i = 0; i < SHOW - 1; i++) begin
            step();
            n_checks++; if (state !== 3'd4) begin
                n_fail++; $display("FAIL show_hold%0d: state=%0d, want 4", i, state); end
        end
        step();
        n_checks++; if (state !== 3'd1 || verdict !== 2'b00) begin
            n_fail++; $display("FAIL show_exit: state=%0d verdict=%b, want 1 00", state, verdict); end
    endtask

    task automatic test_timeout();
        bit ok;
        handshake(9'h0F3);
        expire();
        n_checks++; if (state !== 3'd3) begin
            n_fail++; $display("FAIL timeout_judge: state=%0d, want 3", state); end
        step(); model_judge(1'b0);
        n_checks++; if (verdict !== 2'b10 || score !== 8'(m_score) || round !== 8'(m_round)) begin
            n_fail++; $display("FAIL timeout_verdict: verdict=%b score=%0d round=%0d, want 10 %0d %0d",
                               verdict, score, round, m_score, m_round); end
        leave_show(ok);
        n_checks++; if (!ok || state !== 3'd1) begin
            n_fail++; $display("FAIL timeout_next: ok=%b state=%0d, want 1 1", ok, state); end
    endtask

    task automatic test_collision();
        bit ok;
        handshake(9'h155);
        collide(9'h155);
        n_checks++; if (state !== 3'd3) begin
            n_fail++; $display("FAIL collide_judge: state=%0d, want 3", state); end
        step(); model_judge(1'b1);
        n_checks++; if (verdict !== 2'b11 || score !== 8'(m_score)) begin
            n_fail++; $display("FAIL collide_verdict: verdict=%b score=%0d, want 11 %0d", verdict, score, m_score); end
        leave_show(ok);
        n_checks++; if (!ok || state !== 3'd5 || busy !== 1'b0 || verdict !== 2'b11 || round !== 8'd3) begin
            n_fail++; $display("FAIL done_hold: ok=%b state=%0d busy=%b verdict=%b round=%0d, want 1 5 0 11 3",
                               ok, state, busy, verdict, round); end
    endtask

    task automatic test_full_game();
        bit ok;
        logic [8:0] t;
        pulse_start(); model_new_game();
        n_checks++; if (state !== 3'd1 || score !== 8'd0 || round !== 8'd0) begin
            n_fail++; $display("FAIL restart: state=%0d score=%0d round=%0d, want 1 0 0", state, score, round); end
        for (int r = 0; r < ROUNDS; r++) begin
            t = 9'($urandom);
            handshake(t); press(t); step(); leave_show(ok);
        end
        n_checks++; if (state !== 3'd5 || score !== (BONUS ? 8'd5 : 8'd3) || round !== 8'd3) begin
            n_fail++; $display("FAIL full_game: state=%0d score=%0d round=%0d, want 5 %0d 3",
                               state, score, round, BONUS ? 5 : 3); end
    endtask

    task automatic test_robust();
        pulse_start();
        choose_n = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (state !== 3'd1) begin
            n_fail++; $display("FAIL press_in_req: state=%0d, want 1", state); end
        choose_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        handshake(9'h03C);
        pulse_start();
        n_checks++; if (state !== 3'd2 || score !== 8'd0 || round !== 8'd0) begin
            n_fail++; $display("FAIL start_in_ask: state=%0d score=%0d round=%0d, want 2 0 0", state, score, round); end
        press(9'h03C); step();
        n_checks++; if (state !== 3'd4 || score !== 8'd1) begin
            n_fail++; $display("FAIL robust_show: state=%0d score=%0d, want 4 1", state, score); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0 || score !== 8'd0 || q_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: state=%0d score=%0d q_req=%b busy=%b, want 0 0 0 0",
                               state, score, q_req, busy); end
        step(); reset_n = 1'b1; step();
    endtask

    task automatic test_random();
        bit ok, c;
        logic [8:0] t, a, x;
        int kind;
        for (int g = 0; g < 4; g++) begin
            pulse_start(); model_new_game();
            for (int r = 0; r < ROUNDS; r++) begin
                for (int d = $urandom_range(0, 3); d > 0; d--) step();
                t = 9'($urandom);
                handshake(t);
                for (int d = $urandom_range(0, 2); d > 0; d--) step();
                kind = $urandom_range(0, 4);
                x = 9'($urandom_range(1, 511));
                a = (kind == 1) ? (t ^ x) : t;
                case (kind)
                    0:       expire();
                    4:       collide(a);
                    default: press(a);
                endcase
                c = (kind != 0) && (a == t);
                step(); model_judge(c);
                n_checks++; if (verdict !== {1'b1, c} || score !== 8'(m_score) || round !== 8'(m_round)) begin
                    n_fail++; $display("FAIL rand_g%0d_r%0d: verdict=%b score=%0d round=%0d, want %b %0d %0d",
                                       g, r, verdict, score, round, {1'b1, c}, m_score, m_round); end
                leave_show(ok);
            end
            n_checks++; if (state !== 3'd5 || score !== 8'(m_score)) begin
                n_fail++; $display("FAIL rand_done_g%0d: state=%0d score=%0d, want 5 %0d", g, state, score, m_score); end
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_timeout();
        test_collision();
        test_full_game();
        test_robust();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
